perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of event counters for the MIPS CPU top level. It replaces the fixed three-counter block (total / branch / jump) with CHANNELS configurable event counters plus a dedicated cycle counter. Every counter has a selectable wrap or saturate mode, a sticky overflow flag, an atomic snapshot into shadow registers, and one registered readout port that drives the LED display path. It sits beside the PC enable logic: counting is gated by the same run/halt condition that advances the PC.

## Interface
Parameters:
- WIDTH, 32, bit width of every counter and of rd_data.
- CHANNELS, 4, number of event channels (1..15), excluding the cycle counter.
- SATURATE, 0, selects the counter behaviour at the maximum value. 0 means wrap to 0. 1 means hold at all-ones.
- SELW, 4, width of sel. Must satisfy 2^SELW ≥ CHANNELS+1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- run  in  1  CPU advanced this cycle (PC enable). Gates all counting.
- event  in  CHANNELS  per-channel event strobe, sampled only when run=1.
- clear_cnt  in  1  synchronous clear of live counters and overflow flags.
- snap  in  1  copies all live counters into the shadow registers.
- sel  in  SELW  readout select. 0 selects the cycle counter; k (1..CHANNELS) selects channel k-1.
- rd_data  out  WIDTH  registered shadow value of the selected counter.
- ovf  out  CHANNELS+1  sticky overflow flags. Bit 0 is the cycle counter; bit k is channel k-1.
- snap_valid  out  1  one-cycle pulse on the cycle after a snapshot is captured.

## Operation
- Live counters: cyc plus ev[0..CHANNELS-1], each WIDTH bits.
- Increment rules:
  - cyc increments on every edge with run=1.
  - ev[i] increments on an edge with run=1 and event[i]=1.
  - When run=0, all event strobes are ignored. This is the halted state after syscall.
- At the maximum value (all ones), an increment:
  - sets the corresponding ovf bit (sticky);
  - then, with SATURATE=0, makes the counter 0;
  - or, with SATURATE=1, leaves the counter at all-ones.
- clear_cnt=1:
  - All live counters and all ovf bits become 0 on that edge.
  - Clear wins over a coincident increment: the result is 0, not 1.
  - An overflow in the same cycle is not flagged.
  - Shadow registers are not affected.
- snap=1:
  - Each shadow register is loaded with the live counter value present before this edge's update.
  - With snap and clear_cnt together, the shadow holds the pre-clear values and the live counters become 0.
  - snap_valid goes to 1 on the next cycle for exactly one cycle. Back-to-back snaps give back-to-back pulses.
- Readout:
  - rd_data <= shadow[sel] every edge.
  - If sel > CHANNELS, rd_data <= 0.
  - rd_data never shows live counters directly.
- No internal FSM beyond a snap_valid flop. Counters are free-running and independent.

## Timing
- Reset (clr=1, asynchronous): all live counters = 0, all shadows = 0, ovf = 0, rd_data = 0, snap_valid = 0. All take effect immediately, without waiting for clk.
- Reset mid-operation discards all counts and pending snaps. The first increment after release occurs on the first edge with clr=0 and run=1.
- Increment latency: an event sampled at edge N is visible in the live counter after edge N.
- Snapshot latency:
  - A snap at edge N captures counts through edge N-1.
  - The shadow is valid after edge N.
  - snap_valid is high during cycle N+1.
  - rd_data shows the new shadow after edge N+1 if sel is stable.
- sel change latency: 1 cycle.
- Overflow flag timing: the ovf bit is set on the same edge as the wrapping increment.

## Test plan
- Reset and basic count:
  - Stimulus: clr pulse, then run=1 for 10 cycles with event[0] high on 3 of them, then snap, then sel=0 and sel=1.
  - Required response: rd_data=10, then 3. ovf=0. snap_valid pulses once.
- Run gating:
  - Stimulus: run=0 for 5 cycles with event=all-ones, then run=1 for 2 cycles with event=all-ones, then snap.
  - Required response: every channel reads 2 and cyc reads 2.
- Wrap vs saturate (WIDTH=4):
  - SATURATE=0: 17 events on channel 1 → reads 1, ovf[2]=1.
  - SATURATE=1: 17 events on channel 1 → reads 15, ovf[2]=1.
  - In both cases ovf stays 1 until clear_cnt.
- Simultaneous clear and snap:
  - Stimulus: count cyc to 7, then assert snap and clear_cnt on the same edge with run=1.
  - Required response: shadow cyc=7. After a second snap taken 3 run cycles later, cyc=3 (live started from 0).
- Out-of-range sel:
  - Stimulus: CHANNELS=4, sel=5 and sel=15.
  - Required response: rd_data=0 one cycle later. Returns to the correct value within 1 cycle of sel=2.
- Async reset mid-count:
  - Stimulus: assert clr between clock edges while counters are nonzero and a snap is pending.
  - Required response: all outputs go to 0 before the next edge. No snap_valid pulse follows.

Source files
------------

// File: rtl/perf_counter_bank_if.sv
// Bus bundle for perf_counter_bank: count controls and select in, readout and flags out.
// Ports: run, events, clear_cnt, snap, sel (master -> bank); rd_data, ovf, snap_valid (bank -> master).
// Parameters must match the perf_counter_bank instance that this bundle connects to.
interface perf_counter_bank_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SELW     = 4
);
    logic                run;
    logic [CHANNELS-1:0] events;
    logic                clear_cnt;
    logic                snap;
    logic [SELW-1:0]     sel;
    logic [WIDTH-1:0]    rd_data;
    logic [CHANNELS:0]   ovf;
    logic                snap_valid;

    modport master (
        output run, events, clear_cnt, snap, sel,
        input  rd_data, ovf, snap_valid
    );

    modport slave (
        input  run, events, clear_cnt, snap, sel,
        output rd_data, ovf, snap_valid
    );
endinterface

// File: rtl/perf_counter_bank.sv
// Bank of a cycle counter plus CHANNELS event counters, with shadow snapshot and one readout port.
// Latency: counters update on the sampling edge; rd_data is one register behind the shadow/sel.
// No backpressure: counting is gated only by run; snapshots and reads are always accepted.
// Ports: clk, clr (async active-high reset), bus (slave side of perf_counter_bank_if).
module perf_counter_bank #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0,
    parameter int SELW     = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    perf_counter_bank_if.slave    bus
);
    // Index 0 is the cycle counter, index k is event channel k-1; matches sel and ovf numbering.
    localparam int N = CHANNELS + 1;

    logic [WIDTH-1:0] live   [N];
    logic [WIDTH-1:0] shadow [N];
    logic [N-1:0]     inc;
    logic [N-1:0]     ovf_r;
    logic [WIDTH-1:0] rd_r;
    logic [WIDTH-1:0] rd_next;
    logic             snap_valid_r;

    // Event strobes only count while the CPU is advancing.
    assign inc = {bus.events & {CHANNELS{bus.run}}, bus.run};

    // Out-of-range selects fall through to zero.
    always_comb begin
        rd_next = '0;
        for (int k = 0; k < N; k++) begin
            if (bus.sel == SELW'(k)) begin
                rd_next = shadow[k];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int k = 0; k < N; k++) begin
                live[k]   <= '0;
                shadow[k] <= '0;
            end
            ovf_r        <= '0;
            rd_r         <= '0;
            snap_valid_r <= 1'b0;
        end else begin
            snap_valid_r <= bus.snap;
            rd_r         <= rd_next;
            for (int k = 0; k < N; k++) begin
                // Non-blocking read of live gives the pre-update value, so a coincident
                // clear still lets the shadow capture the old count.
                if (bus.snap) begin
                    shadow[k] <= live[k];
                end
                // Clear has priority: a coincident increment or overflow is dropped.
                if (bus.clear_cnt) begin
                    live[k]  <= '0;
                    ovf_r[k] <= 1'b0;
                end else if (inc[k]) begin
                    if (&live[k]) begin
                        ovf_r[k] <= 1'b1;
                        live[k]  <= (SATURATE != 0) ? live[k] : '0;
                    end else begin
                        live[k] <= live[k] + WIDTH'(1);
                    end
                end
            end
        end
    end

    assign bus.rd_data    = rd_r;
    assign bus.ovf        = ovf_r;
    assign bus.snap_valid = snap_valid_r;
endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 32-bit wrapping bank plus 4-bit wrap and saturate banks
// share the same stimulus; expected readouts are queued when a select is driven and checked after the edge.
module tb_perf_counter_bank;
    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic [3:0] events;
    logic       clear_cnt;
    logic       snap;
    logic [3:0] sel;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    perf_counter_bank_if #(.WIDTH(32), .CHANNELS(4), .SELW(4)) b0 ();
    perf_counter_bank_if #(.WIDTH(4),  .CHANNELS(4), .SELW(4)) bw ();
    perf_counter_bank_if #(.WIDTH(4),  .CHANNELS(4), .SELW(4)) bs ();

    assign b0.run = run;  assign b0.events = events;  assign b0.clear_cnt = clear_cnt;
    assign b0.snap = snap; assign b0.sel = sel;
    assign bw.run = run;  assign bw.events = events;  assign bw.clear_cnt = clear_cnt;
    assign bw.snap = snap; assign bw.sel = sel;
    assign bs.run = run;  assign bs.events = events;  assign bs.clear_cnt = clear_cnt;
    assign bs.snap = snap; assign bs.sel = sel;

    perf_counter_bank #(.WIDTH(32), .CHANNELS(4), .SATURATE(0), .SELW(4)) u0 (.clk(clk), .clr(clr), .bus(b0));
    perf_counter_bank #(.WIDTH(4),  .CHANNELS(4), .SATURATE(0), .SELW(4)) uw (.clk(clk), .clr(clr), .bus(bw));
    perf_counter_bank #(.WIDTH(4),  .CHANNELS(4), .SATURATE(1), .SELW(4)) us (.clk(clk), .clr(clr), .bus(bs));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a select, queue the expected 32-bit-bank readout, check it after the register edge.
    task automatic rd_check(input string tag, input logic [3:0] s, input logic [31:0] e);
        sel = s;
        exp_q.push_back(e);
        step();
        chk(tag, b0.rd_data, exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr = 1'b1; run = 1'b0; events = '0; clear_cnt = 1'b0; snap = 1'b0; sel = '0;
        step(); step();
        chk("reset_rd", b0.rd_data, 0);
        chk("reset_ovf", 32'(b0.ovf), 0);
        chk("reset_snap_valid", 32'(b0.snap_valid), 0);
        clr = 1'b0;

        // Basic count: 10 run cycles, channel 0 event on three of them.
        for (int i = 0; i < 10; i++) begin
            run = 1'b1;
            events = (i == 1 || i == 4 || i == 8) ? 4'b0001 : 4'b0000;
            step();
        end
        run = 1'b0; events = '0; snap = 1'b1;
        step();
        chk("snap_valid_pulse", 32'(b0.snap_valid), 1);
        snap = 1'b0;
        rd_check("basic_cyc", 4'd0, 10);
        chk("snap_valid_single", 32'(b0.snap_valid), 0);
        chk("basic_cyc_w4", 32'(bw.rd_data), 10);
        rd_check("basic_ev0", 4'd1, 3);
        chk("basic_ovf", 32'(b0.ovf), 0);

        // Run gating: events ignored while halted.
        clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
        events = 4'hF;
        for (int i = 0; i < 5; i++) step();
        run = 1'b1;
        for (int i = 0; i < 2; i++) step();
        run = 1'b0; events = '0; snap = 1'b1; step(); snap = 1'b0;
        for (int k = 0; k < 5; k++) rd_check($sformatf("gate_sel%0d", k), 4'(k), 2);

        // Wrap vs saturate on the 4-bit banks: 17 events on channel 1.
        clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
        run = 1'b1; events = 4'b0010;
        for (int i = 0; i < 17; i++) step();
        run = 1'b0; events = '0; snap = 1'b1; step(); snap = 1'b0;
        rd_check("nowrap_ev1_w32", 4'd2, 17);
        chk("wrap_ev1", 32'(bw.rd_data), 1);
        chk("sat_ev1", 32'(bs.rd_data), 15);
        chk("wrap_ovf", 32'(bw.ovf), 32'b00101);
        chk("sat_ovf", 32'(bs.ovf), 32'b00101);
        chk("w32_ovf", 32'(b0.ovf), 0);
        for (int i = 0; i < 3; i++) step();
        chk("wrap_ovf_sticky", 32'(bw.ovf[2]), 1);
        chk("sat_ovf_sticky", 32'(bs.ovf[2]), 1);
        // Clear with a coincident increment on every counter.
        run = 1'b1; events = 4'hF; clear_cnt = 1'b1; step(); clear_cnt = 1'b0;
        chk("wrap_ovf_cleared", 32'(bw.ovf), 0);
        chk("sat_ovf_cleared", 32'(bs.ovf), 0);
        run = 1'b0; events = '0; snap = 1'b1; step(); snap = 1'b0;
        rd_check("clear_beats_inc", 4'd0, 0);

        // Simultaneous clear and snap.
        run = 1'b1;
        for (int i = 0; i < 7; i++) step();
        snap = 1'b1; clear_cnt = 1'b1; step();
        snap = 1'b0; clear_cnt = 1'b0; events = 4'b0010;
        rd_check("snapclr_pre", 4'd0, 7);
        step(); step();
        run = 1'b0; events = '0; snap = 1'b1; step(); snap = 1'b0;
        rd_check("snapclr_post_cyc", 4'd0, 3);
        rd_check("snapclr_post_ev1", 4'd2, 3);

        // Out-of-range select.
        rd_check("sel5", 4'd5, 0);
        chk("sel5_w4", 32'(bw.rd_data), 0);
        rd_check("sel15", 4'd15, 0);
        rd_check("sel_back", 4'd2, 3);

        // Async reset between edges with counts live and a snap in flight.
        run = 1'b1;
        for (int i = 0; i < 3; i++) step();
        run = 1'b0; snap = 1'b1; step();
        chk("prereset_snap_valid", 32'(b0.snap_valid), 1);
        chk("prereset_rd", b0.rd_data, 3);
        #3 clr = 1'b1;
        #1;
        chk("async_rd", b0.rd_data, 0);
        chk("async_snap_valid", 32'(b0.snap_valid), 0);
        chk("async_ovf", 32'(b0.ovf), 0);
        chk("async_rd_w4", 32'(bw.rd_data), 0);
        @(posedge clk); #1;
        clr = 1'b0; snap = 1'b0;
        step();
        chk("postreset_no_pulse", 32'(b0.snap_valid), 0);
        rd_check("postreset_shadow", 4'd2, 0);
        run = 1'b1; step(); step();
        run = 1'b0; snap = 1'b1; step(); snap = 1'b0;
        rd_check("postreset_cyc", 4'd0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
